// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, issues one imem request at a time, holds the fetched instruction for decode.
// Latency: request to if_valid is gnt + rvalid + 1 cycle; a downstream stall (if_ready low) freezes everything in S_HOLD.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        kill_q, kill_d;
    logic        if_valid_q, if_valid_d;
    logic        misalign_q, misalign_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            if_pc_q    <= 32'h0;
            if_instr_q <= NOP_INSTR;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        misalign_d = 1'b0;

        if (redirect_valid) begin
            pc_d       = {redirect_target[31:2], 2'b00};
            misalign_d = |redirect_target[1:0];
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    // A request granted this cycle still owes a response that must be dropped.
                    if (imem_gnt) begin
                        kill_d  = 1'b1;
                        state_d = S_RESP;
                    end
                end
                S_RESP: begin
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    state_d    = S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_RESP;
                    end
                end
                S_RESP: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            if_instr_d = imem_rdata;
                            if_pc_d    = req_pc_q;
                            if_valid_d = 1'b1;
                            state_d    = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (if_ready) begin
                        if_valid_d = 1'b0;
                        if_instr_d = NOP_INSTR;
                        state_d    = S_REQ;
                    end
                end
            endcase
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign misalign  = misalign_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Fetch-stage front end of the 5-stage RISC-V pipeline. Owns the program counter and issues instruction-memory requests over a req/gnt/rvalid handshake. Presents each fetched instruction with its PC to the fetch/decode pipeline register through a valid/ready output. Handles branch/jump redirects from execute, including killing an in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, value driven on if_instr while no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
redirect_valid  input  1  branch/jump taken in execute; single-cycle pulse
redirect_target  input  32  new PC for redirect
imem_req  output  1  instruction-memory request
imem_addr  output  32  request address (= pc)
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_ready  input  1  downstream accepts this cycle
if_pc  output  32  PC of held instruction, feeds the fetch/decode PC register
if_instr  output  32  held instruction
misalign  output  1  one-cycle pulse: redirect_target[1:0] != 0

Behaviour:
- Reset (async, active-high): state=S_IDLE, pc=RESET_PC, kill=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR, misalign=0. imem_req=0 and imem_addr=RESET_PC while in reset.
- imem_req = (state==S_REQ). imem_addr = pc, registered and stable while imem_req is high.
- At most one outstanding memory request. Single-entry output register.
- Peak throughput: one instruction per 3 cycles with a 1-cycle-latency memory and if_ready held high. Request, response and hand-off are serialised.
- pc increments by 4 modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- States:
  - S_IDLE: goes to S_REQ on the next clock after reset release.
  - S_REQ: on imem_gnt, req_pc<=pc, pc<=pc+4, go to S_RESP. Otherwise stay in S_REQ; addr held.
  - S_RESP: waits for imem_rvalid. On rvalid with kill=0: if_instr<=imem_rdata, if_pc<=req_pc, if_valid<=1, go to S_HOLD. On rvalid with kill=1: discard data, kill<=0, go to S_REQ.
  - S_HOLD: if_valid=1, outputs held stable. On if_ready: if_valid<=0, if_instr<=NOP_INSTR, go to S_REQ.
- Redirect takes priority over every other event in the same cycle. pc<=redirect_target & ~32'h3. misalign<=|redirect_target[1:0].
  - S_IDLE or S_REQ without gnt: go to / stay in S_REQ with the new pc. The pending unaccepted request is withdrawn; addr changes.
  - S_REQ with simultaneous gnt: the accepted request is killed. kill<=1, go to S_RESP. pc is not incremented.
  - S_RESP without rvalid: kill<=1, stay in S_RESP.
  - S_RESP with simultaneous rvalid: data discarded, kill<=0, go to S_REQ.
  - S_HOLD (with or without if_ready): if_valid<=0, if_instr<=NOP_INSTR, go to S_REQ. The held instruction is never consumed.
- Redirect never clears kill while a response is still owed. A second redirect during S_RESP with kill=1 only updates pc.
- Asserting rst mid-transaction returns everything to reset values immediately. A response arriving after reset release while in S_IDLE or S_REQ is ignored; the memory is required to abort on rst.
- rvalid outside S_RESP is ignored. gnt outside S_REQ is ignored.

Test Plan:
1. Reset release, memory gnt same cycle, rvalid next cycle with rdata=32'h0050_0093, if_ready=1 -> imem_addr 0,4,8,... on successive requests; if_valid high 1 cycle with if_pc=0, if_instr=32'h0050_0093; next fetch at 4.
2. Hold if_ready=0 for 5 cycles after if_valid rises -> if_pc/if_instr stable, imem_req=0 throughout. On if_ready=1, S_REQ follows with addr=4.
3. Redirect to 32'h0000_0100 in the cycle imem_gnt accepts addr 8 -> response for 8 dropped, if_valid stays 0, next imem_addr=32'h100, then if_pc=32'h100.
4. Redirect to 32'h0000_0200 while in S_RESP, rvalid 3 cycles later -> data discarded, next request addr=32'h200. Repeat with redirect and rvalid in the same cycle -> same outcome.
5. Redirect to 32'h0000_0106 -> pc=32'h104, misalign pulses exactly 1 cycle. Redirect while in S_HOLD -> if_valid drops next cycle, if_instr=32'h0000_0013.
6. Redirect to 32'hFFFF_FFFC, fetch completes -> next imem_addr=32'h0000_0000. Assert rst mid-S_RESP -> all outputs at reset values immediately.
